interp_loop_counter: RTL and testbench

INTERP_LOOP_COUNTER -- requirements
Module: interp_loop_counter

---
 rtl/interp_loop_counter.sv | 113 +++++++++++
 tb/tb_interp_loop_counter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/interp_loop_counter.sv
// Two-level (row, column) loop counter for buffer interpolation: walks columns by a
// latched step up to a latched limit, wraps into the next row, and pulses done at the end.
module interp_loop_counter #(
    parameter int COL_W = 4,
    parameter int ROW_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             stall,
    input  logic [COL_W-1:0] col_last,
    input  logic [ROW_W-1:0] row_last,
    input  logic [COL_W-1:0] col_step,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             valid,
    output logic             last_col,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [COL_W-1:0]   col_last_q;
    logic [COL_W-1:0]   col_step_q;
    logic [ROW_W-1:0]   row_last_q;
    logic [COL_W:0]     col_sum;
    logic               wrap;

    // One extra bit so a limit of all-ones with any step still wraps instead of overflowing.
    assign col_sum = {1'b0, col} + {1'b0, col_step_q};
    assign wrap    = col_sum > {1'b0, col_last_q};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (!stall && wrap && (row == row_last_q)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    always_comb begin
        valid    = 1'b0;
        last_col = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        if (state == RUN) begin
            valid    = !stall;
            last_col = !stall && wrap;
        end
        if (state != IDLE) busy = 1'b1;
        if (state == DONE) done = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            col_last_q <= '0;
            row_last_q <= '0;
            col_step_q <= '0;
        end else begin
            state <= state_nx;
            if (clear) begin
                col <= '0;
                row <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        col <= '0;
                        row <= '0;
                        if (start) begin
                            col_last_q <= col_last;
                            row_last_q <= row_last;
                            // A zero step would never terminate; treat it as unit step.
                            col_step_q <= (col_step == '0) ? COL_W'(1) : col_step;
                        end
                    end
                    RUN: begin
                        if (!stall) begin
                            if (!wrap) begin
                                col <= col_sum[COL_W-1:0];
                            end else if (row != row_last_q) begin
                                col <= '0;
                                row <= row + ROW_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        col <= '0;
                        row <= '0;
                    end
                    default: begin
                        col <= '0;
                        row <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_interp_loop_counter.sv
// Directed bench for interp_loop_counter: single-row, stepped multi-row, stall,
// full-range zero-step, asynchronous reset and clear scenarios.
module tb_interp_loop_counter;

    logic       clk;
    logic       rst;
    logic       start;
    logic       clear;
    logic       stall;
    logic [3:0] col_last;
    logic [3:0] row_last;
    logic [3:0] col_step;
    logic [3:0] col;
    logic [3:0] row;
    logic       valid;
    logic       last_col;
    logic       busy;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;

    interp_loop_counter #(.COL_W(4), .ROW_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .clear    (clear),
        .stall    (stall),
        .col_last (col_last),
        .row_last (row_last),
        .col_step (col_step),
        .col      (col),
        .row      (row),
        .valid    (valid),
        .last_col (last_col),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic lc, input int c,
                           input int r, input logic b, input logic d);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".last_col"}, 32'(last_col), 32'(lc));
        chk({tag, ".col"}, 32'(col), c);
        chk({tag, ".row"}, 32'(row), r);
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ecol;
        int st;
        int nvalid;

        rst = 1'b1; start = 1'b0; clear = 1'b0; stall = 1'b0;
        col_last = '0; row_last = '0; col_step = '0;
        #2;
        chk_out("reset", 0, 0, 0, 0, 0, 0);
        cyc(); cyc();
        rst = 1'b0;

        // Single row, 14 columns, unit step
        col_last = 4'd13; row_last = 4'd0; col_step = 4'd1; start = 1'b1;
        #1; chk_out("t1.idle", 0, 0, 0, 0, 0, 0);
        cyc();
        start = 1'b0;
        for (int k = 0; k < 14; k++) begin
            #1; chk_out("t1.run", 1, k == 13, k, 0, 1, 0);
            cyc();
        end
        #1; chk_out("t1.done", 0, 0, 13, 0, 1, 1);
        cyc();
        #1; chk_out("t1.after", 0, 0, 0, 0, 0, 0);

        // Step 4 over three rows; inputs scrambled mid-run must not matter
        col_last = 4'd13; row_last = 4'd2; col_step = 4'd4; start = 1'b1;
        cyc();
        start = 1'b0; col_last = 4'd0; row_last = 4'd0; col_step = 4'd1;
        nvalid = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 16; c += 4) begin
                #1; chk_out("t2.run", 1, c == 12, c, r, 1, 0);
                if (valid) nvalid++;
                cyc();
            end
        end
        chk("t2.count", 32'(nvalid), 32'd12);
        #1; chk_out("t2.done", 0, 0, 12, 2, 1, 1);
        cyc();
        #1; chk_out("t2.after", 0, 0, 0, 0, 0, 0);

        // Three-cycle stall while col sits at 5
        col_last = 4'd13; row_last = 4'd0; col_step = 4'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        ecol = 0; st = 0; nvalid = 0;
        for (int i = 0; i < 17; i++) begin
            stall = (ecol == 5) && (st < 3);
            if (stall) st++;
            #1;
            chk("t3.valid", 32'(valid), 32'(!stall));
            chk("t3.col", 32'(col), ecol);
            chk("t3.last_col", 32'(last_col), 32'(!stall && ecol == 13));
            if (valid) nvalid++;
            if (!stall) ecol++;
            cyc();
        end
        stall = 1'b0;
        chk("t3.count", 32'(nvalid), 32'd14);
        #1; chk_out("t3.done", 0, 0, 13, 0, 1, 1);
        cyc();

        // Full column range with zero step; start pulses during RUN and DONE are ignored
        col_last = 4'd15; row_last = 4'd1; col_step = 4'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            start = (k == 3);
            #1; chk_out("t4.run", 1, (k % 16) == 15, k % 16, k / 16, 1, 0);
            cyc();
        end
        start = 1'b1;
        #1; chk_out("t4.done", 0, 0, 15, 1, 1, 1);
        cyc();
        start = 1'b0;
        #1; chk_out("t4.after", 0, 0, 0, 0, 0, 0);
        cyc();
        #1; chk_out("t4.idle", 0, 0, 0, 0, 0, 0);

        // Asynchronous reset at col 7, row 1
        col_last = 4'd13; row_last = 4'd2; col_step = 4'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 21; k++) cyc();
        #1; chk_out("t5.pre", 1, 0, 7, 1, 1, 0);
        #1; rst = 1'b1;
        #1; chk_out("t5.rst", 0, 0, 0, 0, 0, 0);
        #1; rst = 1'b0;
        cyc();
        #1; chk_out("t5.post", 0, 0, 0, 0, 0, 0);
        cyc();
        #1; chk_out("t5.post2", 0, 0, 0, 0, 0, 0);

        // Fresh run after reset, then clear at col 3 (clear beats a simultaneous start)
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1; chk_out("t6.run", 1, 0, k, 0, 1, 0);
            cyc();
        end
        clear = 1'b1; start = 1'b1;
        #1; chk_out("t6.clrcyc", 1, 0, 3, 0, 1, 0);
        cyc();
        clear = 1'b0; start = 1'b0;
        #1; chk_out("t6.cleared", 0, 0, 0, 0, 0, 0);
        cyc();
        #1; chk_out("t6.idle", 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
